// File: rtl/biquad_pkg.sv
// Shared constants, coefficient-FSM state type and the saturating slice helper
// for the multi-sample biquad pole section.
package biquad_pkg;

  localparam int ACC_BITS   = 48;
  localparam int ACC_FRAC   = 27;
  localparam int FB_FRAC    = 13;
  localparam int COEFF_FRAC = 14;
  localparam int FB_BITS    = 30;

  typedef enum logic [1:0] {
    COEFF_IDLE    = 2'd0,
    COEFF_LOADING = 2'd1,
    COEFF_READY   = 2'd2
  } coeff_state_t;

  typedef struct packed {
    logic                ovf;
    logic [ACC_BITS-1:0] val;
  } sat_t;

  // Arithmetic right shift by lsb, clamped to the signed range of width bits.
  // The result is sign-extended to ACC_BITS; callers truncate to width.
  function automatic sat_t sat_slice(input logic [ACC_BITS-1:0] acc,
                                     input int lsb, input int width);
    logic signed [ACC_BITS-1:0] sh;
    logic signed [ACC_BITS-1:0] mx;
    logic signed [ACC_BITS-1:0] mn;
    sat_t r;
    sh = $signed(acc) >>> lsb;
    mx = (ACC_BITS'(1) <<< (width - 1)) - ACC_BITS'(1);
    mn = ~mx;
    r.ovf = 1'b0;
    r.val = sh;
    if (sh > mx) begin
      r.ovf = 1'b1;
      r.val = mx;
    end else if (sh < mn) begin
      r.ovf = 1'b1;
      r.val = mn;
    end
    return r;
  endfunction

endpackage

// File: rtl/biquad_pole_coeff_ctrl.sv
// Coefficient loader: row-major writes fill a shadow bank, a checked update
// copies it to the active bank. Exposes FSM state for observation.
module biquad_pole_coeff_ctrl
  import biquad_pkg::*;
#(
  parameter int NOUT       = 2,
  parameter int COEFF_BITS = 18
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COEFF_BITS-1:0]             coeff_dat_i,
  input  logic                              coeff_wr_i,
  input  logic                              coeff_update_i,
  output logic [NOUT*NOUT*COEFF_BITS-1:0]   active_o,
  output logic [1:0]                        state_o,
  output logic                              err_o
);

  localparam int N2     = NOUT * NOUT;
  localparam int WIDX_W = (N2 > 1) ? $clog2(N2) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(N2 - 1);

  coeff_state_t          state, state_nx;
  logic [WIDX_W-1:0]     widx, widx_nx, wr_idx;
  logic                  wr_en, copy_en, err_nx;
  logic [COEFF_BITS-1:0] shadow [N2];

  always_comb begin
    state_nx = state;
    widx_nx  = widx;
    wr_idx   = '0;
    wr_en    = coeff_wr_i;
    copy_en  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      COEFF_IDLE: begin
        err_nx = coeff_update_i;
        if (coeff_wr_i) begin
          if (N2 == 1) begin
            state_nx = COEFF_READY;
            widx_nx  = '0;
          end else begin
            state_nx = COEFF_LOADING;
            widx_nx  = WIDX_W'(1);
          end
        end
      end
      COEFF_LOADING: begin
        err_nx = coeff_update_i;
        if (coeff_wr_i) begin
          wr_idx = widx;
          if (widx == WIDX_LAST) begin
            state_nx = COEFF_READY;
            widx_nx  = '0;
          end else begin
            widx_nx = widx + 1'b1;
          end
        end
      end
      COEFF_READY: begin
        // A same-cycle write still reaches the copy with the pre-write shadow,
        // because the copy reads the registered bank.
        if (coeff_update_i) begin
          copy_en  = 1'b1;
          state_nx = COEFF_IDLE;
        end
        if (coeff_wr_i) begin
          if (N2 == 1) begin
            state_nx = COEFF_READY;
            widx_nx  = '0;
          end else begin
            state_nx = COEFF_LOADING;
            widx_nx  = WIDX_W'(1);
          end
        end
      end
      default: state_nx = COEFF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COEFF_IDLE;
      widx     <= '0;
      err_o    <= 1'b0;
      active_o <= '0;
      for (int k = 0; k < N2; k++) shadow[k] <= '0;
    end else begin
      state <= state_nx;
      widx  <= widx_nx;
      err_o <= err_nx;
      if (wr_en) shadow[wr_idx] <= coeff_dat_i;
      if (copy_en) begin
        for (int k = 0; k < N2; k++) active_o[k*COEFF_BITS +: COEFF_BITS] <= shadow[k];
      end
    end
  end

  assign state_o = state;

endmodule

// File: rtl/biquad_pole_iir_mat.sv
// Pole section for the multi-sample biquad: y = K * y(-2) + FIR partial sum.
// Define BIQUAD_POLE_IIR_SAT_EN to saturate the feedback and output slices.
module biquad_pole_iir_mat #(
  parameter int NOUT       = 2,
  parameter int NBITS      = 24,
  parameter int NFRAC      = 10,
  parameter int COEFF_BITS = 18,
  parameter int FB_BITS    = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COEFF_BITS-1:0]   coeff_dat_i,
  input  logic                    coeff_wr_i,
  input  logic                    coeff_update_i,
  output logic                    coeff_ready_o,
  output logic                    coeff_err_o,
  input  logic [NOUT*48-1:0]      fir_i,
  output logic [NOUT*NBITS-1:0]   y_o,
  output logic                    ovf_o
);
  import biquad_pkg::*;

  localparam int FB_LSB = ACC_FRAC - FB_FRAC;
  localparam int Y_LSB  = ACC_FRAC - NFRAC;

  logic [NOUT*NOUT*COEFF_BITS-1:0] k_flat;
  logic [1:0]                      ctrl_state;

  biquad_pole_coeff_ctrl #(
    .NOUT       (NOUT),
    .COEFF_BITS (COEFF_BITS)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .coeff_dat_i    (coeff_dat_i),
    .coeff_wr_i     (coeff_wr_i),
    .coeff_update_i (coeff_update_i),
    .active_o       (k_flat),
    .state_o        (ctrl_state),
    .err_o          (coeff_err_o)
  );

  assign coeff_ready_o = (ctrl_state == COEFF_READY);

  logic signed [ACC_BITS-1:0] fir_d  [NOUT];
  logic signed [ACC_BITS-1:0] acc    [NOUT];
  logic signed [ACC_BITS-1:0] acc_nx [NOUT];
  logic signed [ACC_BITS-1:0] p      [NOUT][NOUT];
  logic signed [FB_BITS-1:0]  fb     [NOUT];
  logic [NBITS-1:0]           y_nx   [NOUT];
  logic [NBITS-1:0]           y_q    [NOUT];

`ifdef BIQUAD_POLE_IIR_SAT_EN
  logic sat_any;
  logic ovf_q;

  always_comb begin : slice_sat
    sat_t r_fb;
    sat_t r_y;
    sat_any = 1'b0;
    for (int j = 0; j < NOUT; j++) begin
      r_fb    = sat_slice(acc[j], FB_LSB, FB_BITS);
      r_y     = sat_slice(acc[j], Y_LSB, NBITS);
      fb[j]   = FB_BITS'(r_fb.val);
      y_nx[j] = NBITS'(r_y.val);
      sat_any = sat_any | r_fb.ovf | r_y.ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_q | sat_any;
  end

  assign ovf_o = ovf_q;
`else
  // Plain slices: out-of-range values wrap.
  always_comb begin
    for (int j = 0; j < NOUT; j++) begin
      fb[j]   = FB_BITS'(acc[j] >>> FB_LSB);
      y_nx[j] = NBITS'(acc[j] >>> Y_LSB);
    end
  end

  assign ovf_o = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NOUT; i++) begin
      acc_nx[i] = fir_d[i];
      for (int j = 0; j < NOUT; j++) acc_nx[i] = acc_nx[i] + p[i][j];
    end
  end

  // Coefficient Q4.14 times feedback frac-13 lands directly on the frac-27 grid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NOUT; i++) begin
        fir_d[i] <= '0;
        acc[i]   <= '0;
        y_q[i]   <= '0;
        for (int j = 0; j < NOUT; j++) p[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        fir_d[i] <= fir_i[48*i +: 48];
        acc[i]   <= acc_nx[i];
        y_q[i]   <= y_nx[i];
        for (int j = 0; j < NOUT; j++) begin
          p[i][j] <= ACC_BITS'($signed(k_flat[(i*NOUT+j)*COEFF_BITS +: COEFF_BITS]))
                   * ACC_BITS'(fb[j]);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NOUT; i++) y_o[NBITS*i +: NBITS] = y_q[i];
  end

endmodule

// File: tb/tb_biquad_pole_iir_mat.sv
// Directed bench for biquad_pole_iir_mat (NOUT=2): per-cycle vector table plus
// a long saturation/wrap run; honours BIQUAD_POLE_IIR_SAT_EN.
module tb_biquad_pole_iir_mat;

  localparam logic [47:0] IMP   = 48'h0000_0800_0000;  // 1.0 in Q21.27
  localparam logic [23:0] Y_MAX = 24'h7F_FFFF;

  logic          clk;
  logic          rst;
  logic [17:0]   coeff_dat_i;
  logic          coeff_wr_i;
  logic          coeff_update_i;
  logic          coeff_ready_o;
  logic          coeff_err_o;
  logic [95:0]   fir_i;
  logic [47:0]   y_o;
  logic          ovf_o;

  int n_checks = 0;
  int n_errors = 0;

  biquad_pole_iir_mat dut (
    .clk            (clk),
    .rst            (rst),
    .coeff_dat_i    (coeff_dat_i),
    .coeff_wr_i     (coeff_wr_i),
    .coeff_update_i (coeff_update_i),
    .coeff_ready_o  (coeff_ready_o),
    .coeff_err_o    (coeff_err_o),
    .fir_i          (fir_i),
    .y_o            (y_o),
    .ovf_o          (ovf_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        wr;
    logic        upd;
    logic [17:0] dat;
    logic [47:0] f0;
    logic [47:0] f1;
    logic [23:0] y0;
    logic [23:0] y1;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic w, logic u, logic [17:0] d,
                              logic [47:0] a, logic [47:0] b,
                              logic [23:0] e0, logic [23:0] e1, logic erdy, logic eerr);
    vec_t v;
    v.rst = r; v.wr = w; v.upd = u; v.dat = d; v.f0 = a; v.f1 = b;
    v.y0 = e0; v.y1 = e1; v.rdy = erdy; v.err = eerr;
    vecs.push_back(v);
  endfunction

  // driver: present inputs, advance one edge, settle
  task automatic apply(input logic r, input logic w, input logic u, input logic [17:0] d,
                       input logic [47:0] a, input logic [47:0] b);
    rst = r; coeff_wr_i = w; coeff_update_i = u; coeff_dat_i = d;
    fir_i = {b, a};
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load4(input logic [17:0] k00, input logic [17:0] k01,
                       input logic [17:0] k10, input logic [17:0] k11);
    apply(0, 1, 0, k00, 0, 0);
    apply(0, 1, 0, k01, 0, 0);
    apply(0, 1, 0, k10, 0, 0);
    apply(0, 1, 0, k11, 0, 0);
  endtask

  initial begin : main
    logic saw_neg;
    rst = 1'b1; coeff_wr_i = 1'b0; coeff_update_i = 1'b0; coeff_dat_i = '0; fir_i = '0;

    // reset
    add(1,0,0,0,0,0, 0,0,0,0);
    // K00 = 0.5, lane0 impulse: 1024,0,512,0,256,0,128
    add(0,1,0,8192,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,    0,0,0,0);
    add(0,1,0,0,0,0,    0,0,0,0);
    add(0,1,0,0,0,0,    0,0,1,0);
    add(0,0,1,0,0,0,    0,0,0,0);
    add(0,0,0,0,IMP,0,  0,0,0,0);
    add(0,0,0,0,0,0,    0,0,0,0);
    add(0,0,0,0,0,0,    1024,0,0,0);
    add(0,0,0,0,0,0,    0,0,0,0);
    add(0,0,0,0,0,0,    512,0,0,0);
    add(0,0,0,0,0,0,    0,0,0,0);
    add(0,0,0,0,0,0,    256,0,0,0);
    add(0,0,0,0,0,0,    0,0,0,0);
    add(0,0,0,0,0,0,    128,0,0,0);
    add(1,0,0,0,0,0,    0,0,0,0);
    // cross term K01 = 1.0, lane1 impulse
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,16384,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     0,0,1,0);
    add(0,0,1,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,IMP,   0,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     0,1024,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     1024,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    // update after 3 of 4 writes is rejected; old K01 still acts
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,0,1,0,0,IMP,   0,0,0,1);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     0,1024,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     1024,0,0,0);
    add(0,1,0,16384,0,0, 0,0,1,0);
    add(0,0,1,0,0,0,     0,0,0,0);
    // new K11 = 1.0: lane1 rings undamped, lane0 silent
    add(0,0,0,0,0,IMP,   0,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     0,1024,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     0,1024,0,0);
    add(1,0,0,0,0,0,     0,0,0,0);
    // write+update in READY: old shadow (K00=0.5) copied, reload from index 1
    add(0,1,0,8192,0,0,  0,0,0,0);
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     0,0,1,0);
    add(0,1,1,16384,0,0, 0,0,0,0);
    add(0,1,0,0,IMP,0,   0,0,0,0);
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     1024,0,1,0);
    add(0,0,1,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     512,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     512,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     512,0,0,0);
    // reset mid-load with live outputs; update afterwards is rejected
    add(0,1,0,0,0,0,     0,0,0,0);
    add(0,1,0,0,0,0,     512,0,0,0);
    add(1,0,0,0,0,0,     0,0,0,0);
    add(0,0,1,0,0,0,     0,0,0,1);
    add(0,0,0,0,IMP,0,   0,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     1024,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);
    add(0,0,0,0,0,0,     0,0,0,0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].wr, vecs[i].upd, vecs[i].dat, vecs[i].f0, vecs[i].f1);
      check($sformatf("v%0d y0", i),  48'(y_o[23:0]),   48'(vecs[i].y0));
      check($sformatf("v%0d y1", i),  48'(y_o[47:24]),  48'(vecs[i].y1));
      check($sformatf("v%0d rdy", i), 48'(coeff_ready_o), 48'(vecs[i].rdy));
      check($sformatf("v%0d err", i), 48'(coeff_err_o),   48'(vecs[i].err));
      check($sformatf("v%0d ovf", i), 48'(ovf_o),         48'd0);
    end

    // K00 = 1.5 with constant unit input: unstable growth
    apply(1, 0, 0, 0, 0, 0);
    load4(18'd24576, 0, 0, 0);
    check("sat load rdy", 48'(coeff_ready_o), 48'd1);
    apply(0, 0, 1, 0, 0, 0);
    saw_neg = 1'b0;
    for (int c = 0; c < 200; c++) begin
      apply(0, 0, 0, 0, IMP, 0);
      if (y_o[23]) saw_neg = 1'b1;
    end
`ifdef BIQUAD_POLE_IIR_SAT_EN
    for (int c = 0; c < 4; c++) begin
      check($sformatf("sat hold y0 %0d", c), 48'(y_o[23:0]), 48'(Y_MAX));
      check($sformatf("sat ovf %0d", c), 48'(ovf_o), 48'd1);
      apply(0, 0, 0, 0, IMP, 0);
    end
    check("sat never negative", 48'(saw_neg), 48'd0);
`else
    check("wrap went negative", 48'(saw_neg), 48'd1);
    check("wrap ovf tied low", 48'(ovf_o), 48'd0);
`endif
    apply(1, 0, 0, 0, 0, 0);
    check("post-rst ovf", 48'(ovf_o), 48'd0);
    check("post-rst y0", 48'(y_o[23:0]), 48'd0);
    check("post-rst rdy", 48'(coeff_ready_o), 48'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/biquad_pole_iir_mat.md
# biquad_pole_iir_mat

Parametrised pole (feedback) section for the multi-sample-per-clock biquad: NOUT parallel outputs share a full NOUT×NOUT feedback coefficient matrix applied to the outputs from two clocks earlier. Each output is that matrix product plus a 48-bit FIR partial sum. It sits directly after the biquad zero/FIR section and generalises the fixed two-output pole stage to any NOUT. It adds a checked coefficient-load state machine, double-buffered coefficients and optional saturation.

## Interface
- NOUT, 2: number of parallel outputs; matrix is NOUT×NOUT, loop latency fixed at 2 clocks.
- NBITS, 24: output width.
- NFRAC, 10: output fractional bits.
- COEFF_BITS, 18: signed coefficient width, Q4.14 (COEFF_FRAC=14, fixed).
- FB_BITS, 30: signed feedback operand width, FB_FRAC=13 (fixed).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- coeff_dat_i  in  COEFF_BITS  coefficient word, row-major order (K[0][0], K[0][1], …).
- coeff_wr_i  in  1  write coeff_dat_i into the shadow bank at the current index.
- coeff_update_i  in  1  request shadow→active copy.
- coeff_ready_o  out  1  full matrix present in shadow; update is allowed.
- coeff_err_o  out  1  one-cycle pulse: update rejected.
- fir_i  in  NOUT*48  FIR partial sums, lane i at [48*i +: 48], Q21.27 (ACC_FRAC=27).
- y_o  out  NOUT*NBITS  outputs, lane i at [NBITS*i +: NBITS].
- ovf_o  out  1  sticky overflow flag; constant 0 without saturation.

## Operation
- Datapath per lane i:
  - fir_d_i <= fir_i
  - fb_j = slice(acc_j), bits [ACC_FRAC-FB_FRAC +: FB_BITS]
  - p_ij <= K_ij * fb_j (registered; 48-bit signed; frac 27)
  - acc_i <= fir_d_i + Σ_j p_ij (48-bit, wraps modulo 2^48)
  - y_i <= acc_i[ACC_FRAC-NFRAC +: NBITS]
- Coefficient FSM, states IDLE / LOADING / READY; write index widx 0..NOUT²-1:
  - IDLE: write → shadow[0], widx=1, go to LOADING. If NOUT²=1, go to READY instead.
  - LOADING: each write fills shadow[widx] and increments widx. The write to index NOUT²-1 → READY, widx=0.
  - READY: update → active <= shadow, go to IDLE. Write → overwrites shadow[0], widx=1, go to LOADING, coeff_ready_o drops.
  - Update in IDLE or LOADING: ignored, coeff_err_o pulses, state and widx unchanged.
  - Write and update in the same cycle, in READY: the copy uses the pre-write shadow, the write lands at shadow[0], next state is LOADING. Same event in IDLE/LOADING: the write proceeds and the update is rejected with an error pulse.
  - An active-bank change takes effect on products registered in the cycle after the update edge.
- Reset clears shadow, active, widx, all pipeline registers, acc and y_o. It also clears ovf_o and returns the FSM to IDLE. All outputs read 0 after the reset edge; reset mid-load discards the partial matrix.

## Timing
- fir_i sampled at edge e → acc at e+1 → y_o at e+2. Latency is 2 clocks.
- Feedback: acc at edge e contributes to acc at edge e+2.
- coeff_ready_o, coeff_err_o and ovf_o are registered, asserted the edge after the causing input.
- Throughput: one vector per clock, no stall.

## Configuration
- BIQUAD_POLE_IIR_SAT_EN defined: the fb_j slice and the y_i slice saturate to the signed min/max of their width when the discarded upper acc bits are not a sign extension. Any saturation sets ovf_o, which stays set until rst.
- Undefined: plain bit slices, so wrap-around truncation applies; ovf_o is tied to 0.

## Structure
- Package biquad_pkg: ACC_FRAC=27, FB_FRAC=13, COEFF_FRAC=14, FB_BITS, the FSM state enum, and the saturating-slice function.
- Sub-module biquad_pole_coeff_ctrl: FSM, widx, shadow/active banks; exports the active matrix flat.

## Test plan
- NOUT=2, load K=[[8192,0],[0,0]] (K00=0.5), update, then fir lane0 impulse 1<<27 for one cycle → y0 = 1024, 0, 512, 0, 256 on consecutive cycles starting 2 cycles after the impulse; y1 = 0 throughout.
- Cross term: K=[[0,16384],[0,0]], fir lane1 impulse 1<<27 → y1 = 1024 at +2; y0 = 1024 at +4.
- Update after 3 of 4 writes → coeff_err_o pulses, output unchanged; 4th write → coeff_ready_o=1; update → new K used.
- Simultaneous wr+update in READY → old shadow copied, FSM in LOADING with widx=1, coeff_ready_o=0.
- With SAT_EN: K00=24576 (1.5), constant fir 1<<27 → y0 climbs to 2^23-1 and holds; ovf_o=1 until rst. Without SAT_EN: y0 wraps negative.
- rst asserted mid-load and while outputs are nonzero → all outputs 0 next cycle; an update before a fresh full load → coeff_err_o.
